// File: rtl/ln_pkg.sv
// ln_pkg: shared types and defaults for the inverse-sqrt request scheduler.
// Holds the per-bank slot states, the flush FSM states and the default sizes.
package ln_pkg;
   typedef enum logic [1:0] {FREE, PEND, FLY, HELD} bank_state_t;
   typedef enum logic [1:0] {RUN, DRAIN, DONE} fsm_state_t;
   localparam int NUM_BANKS_DEF   = 4;
   localparam int PWL_LATENCY_DEF = 12;
   localparam int BANK_ID_W       = 2;
endpackage

// File: rtl/ln_isqrt_sched_if.sv
// ln_isqrt_sched_if: bank request, shared-stage and per-bank result channels of the scheduler.
// slave = scheduler view (consumes i_*, drives o_*); master = environment view.
interface ln_isqrt_sched_if import ln_pkg::*; #(
   parameter int NUM_BANKS = NUM_BANKS_DEF,
   parameter int MEAN_W    = 32,
   parameter int VAR_W     = 16,
   parameter int ISQ_W     = 16
);
   logic                        i_en;
   logic [NUM_BANKS-1:0]        i_req_valid;
   logic [NUM_BANKS*MEAN_W-1:0] i_req_mean;
   logic [NUM_BANKS*VAR_W-1:0]  i_req_var;
   logic [NUM_BANKS-1:0]        o_req_ready;
   logic                        o_calc_en;
   logic                        o_calc_valid;
   logic [BANK_ID_W-1:0]        o_calc_bank_id;
   logic [MEAN_W-1:0]           o_calc_mean;
   logic [VAR_W-1:0]            o_calc_var;
   logic                        i_res_valid;
   logic [BANK_ID_W-1:0]        i_res_bank_id;
   logic [MEAN_W-1:0]           i_res_mean;
   logic [ISQ_W-1:0]            i_res_isq;
   logic [NUM_BANKS-1:0]        o_res_valid;
   logic [NUM_BANKS-1:0]        i_res_ready;
   logic [NUM_BANKS*MEAN_W-1:0] o_res_mean;
   logic [NUM_BANKS*ISQ_W-1:0]  o_res_isq;
   logic                        i_flush;
   logic                        o_flush_done;
   logic                        o_idle;
   logic                        o_err;
   modport slave (
      input  i_en, i_req_valid, i_req_mean, i_req_var, i_res_valid, i_res_bank_id,
             i_res_mean, i_res_isq, i_res_ready, i_flush,
      output o_req_ready, o_calc_en, o_calc_valid, o_calc_bank_id, o_calc_mean, o_calc_var,
             o_res_valid, o_res_mean, o_res_isq, o_flush_done, o_idle, o_err
   );
   modport master (
      output i_en, i_req_valid, i_req_mean, i_req_var, i_res_valid, i_res_bank_id,
             i_res_mean, i_res_isq, i_res_ready, i_flush,
      input  o_req_ready, o_calc_en, o_calc_valid, o_calc_bank_id, o_calc_mean, o_calc_var,
             o_res_valid, o_res_mean, o_res_isq, o_flush_done, o_idle, o_err
   );
endinterface

// File: rtl/ln_rr_arb.sv
// ln_rr_arb: round-robin arbiter, first request at or above ptr (with wrap) wins.
// req: request vector, ptr: search start, en: allow grant; gnt: one-hot, idx: index, vld: any grant.
module ln_rr_arb #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         en,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         vld
);
   logic [W-1:0] j;
   always_comb begin
      vld = 1'b0;
      idx = '0;
      j   = '0;
      for (int i = 0; i < N; i++) begin
         j = W'((int'(ptr) + i) % N);
         if (en && !vld && req[j]) begin
            vld = 1'b1;
            idx = j;
         end
      end
      gnt = vld ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/ln_isqrt_sched.sv
// ln_isqrt_sched: per-bank request slots feeding one shared inverse-sqrt stage, with flush/drain.
// i_clk/i_rst_n: clock and async active-low reset; bus: request, calc issue, result and flush channels.
module ln_isqrt_sched import ln_pkg::*; #(
   parameter int NUM_BANKS   = NUM_BANKS_DEF,
   parameter int PWL_LATENCY = PWL_LATENCY_DEF,
   parameter int MEAN_W      = 32,
   parameter int VAR_W       = 16,
   parameter int ISQ_W       = 16
) (
   input logic            i_clk,
   input logic            i_rst_n,
   ln_isqrt_sched_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_BANKS + 1);

   // bank ids are 2 bits wide and the shared stage needs at least one cycle of latency
   if (NUM_BANKS < 2 || NUM_BANKS > 4 || PWL_LATENCY < 1) begin : g_bad_cfg
      $error("ln_isqrt_sched: unsupported NUM_BANKS or PWL_LATENCY");
   end

   bank_state_t          st [NUM_BANKS];
   fsm_state_t           fsm;
   logic [BANK_ID_W-1:0] rr_ptr, gnt_idx;
   logic [NUM_BANKS-1:0] pend_v, fly_v, free_v, gnt;
   logic                 gnt_vld, res_hit, res_ok;
   logic [CNT_W-1:0]     fly_cnt;
   logic [MEAN_W-1:0]    slot_mean [NUM_BANKS];
   logic [VAR_W-1:0]     slot_var [NUM_BANKS];

   always_comb begin
      pend_v  = '0;
      fly_v   = '0;
      free_v  = '0;
      res_hit = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         pend_v[b] = st[b] == PEND;
         fly_v[b]  = st[b] == FLY;
         free_v[b] = st[b] == FREE;
         res_hit   = res_hit | (fly_v[b] & (bus.i_res_bank_id == BANK_ID_W'(b)));
      end
   end

   // a result is only legal for a bank actually in flight
   assign res_ok          = bus.i_res_valid & res_hit & (fly_cnt != '0);
   assign bus.o_req_ready = (fsm == RUN) ? free_v : '0;
   assign bus.o_idle      = (&free_v) & (fsm == RUN);
   assign bus.o_calc_en   = bus.i_en;

   ln_rr_arb #(.N(NUM_BANKS), .W(BANK_ID_W)) u_arb (
      .req (pend_v),
      .ptr (rr_ptr),
      .en  (bus.i_en),
      .gnt (gnt),
      .idx (gnt_idx),
      .vld (gnt_vld)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fsm                <= RUN;
         rr_ptr             <= '0;
         fly_cnt            <= '0;
         bus.o_calc_valid   <= 1'b0;
         bus.o_calc_bank_id <= '0;
         bus.o_calc_mean    <= '0;
         bus.o_calc_var     <= '0;
         bus.o_res_valid    <= '0;
         bus.o_res_mean     <= '0;
         bus.o_res_isq      <= '0;
         bus.o_flush_done   <= 1'b0;
         bus.o_err          <= 1'b0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            st[b]        <= FREE;
            slot_mean[b] <= '0;
            slot_var[b]  <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            case (st[b])
               FREE: if (bus.i_req_valid[b] && bus.o_req_ready[b]) begin
                  st[b]        <= PEND;
                  slot_mean[b] <= bus.i_req_mean[b*MEAN_W +: MEAN_W];
                  slot_var[b]  <= bus.i_req_var[b*VAR_W +: VAR_W];
               end
               PEND: if (gnt[b]) st[b] <= FLY;
               FLY: if (res_ok && bus.i_res_bank_id == BANK_ID_W'(b)) begin
                  st[b]                              <= HELD;
                  bus.o_res_valid[b]                 <= 1'b1;
                  bus.o_res_mean[b*MEAN_W +: MEAN_W] <= bus.i_res_mean;
                  bus.o_res_isq[b*ISQ_W +: ISQ_W]    <= bus.i_res_isq;
               end
               default: if (bus.i_res_ready[b]) begin
                  st[b]              <= FREE;
                  bus.o_res_valid[b] <= 1'b0;
               end
            endcase
         end
         // with the stage stalled the issue register and pointer simply hold
         if (bus.i_en) begin
            bus.o_calc_valid <= gnt_vld;
            if (gnt_vld) begin
               bus.o_calc_bank_id <= gnt_idx;
               bus.o_calc_mean    <= slot_mean[gnt_idx];
               bus.o_calc_var     <= slot_var[gnt_idx];
               rr_ptr             <= (gnt_idx == BANK_ID_W'(NUM_BANKS - 1)) ? '0 : gnt_idx + 1'b1;
            end
         end
         fly_cnt          <= fly_cnt + CNT_W'(gnt_vld) - CNT_W'(res_ok);
         bus.o_err        <= bus.o_err | (bus.i_res_valid & ~res_ok);
         bus.o_flush_done <= (fsm == DRAIN) && !(|(pend_v | fly_v));
         fsm              <= (fsm == RUN)   ? (bus.i_flush ? DRAIN : RUN) :
                             (fsm == DRAIN) ? ((|(pend_v | fly_v)) ? DRAIN : DONE) : RUN;
      end
   end
endmodule

// File: tb/tb_ln_isqrt_sched.sv
// tb_ln_isqrt_sched: directed checks of issue order, stall, back-pressure, flush, error and reset.
module tb_ln_isqrt_sched;
   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   int   n_vec   = 0;
   int   n_bad   = 0;

   always #5 i_clk = ~i_clk;

   ln_isqrt_sched_if #(.NUM_BANKS(4), .MEAN_W(32), .VAR_W(16), .ISQ_W(16)) bus ();

   ln_isqrt_sched #(.NUM_BANKS(4), .PWL_LATENCY(12), .MEAN_W(32), .VAR_W(16), .ISQ_W(16)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_req(input int b, input logic [31:0] m, input logic [15:0] v);
      bus.i_req_valid[b]         = 1'b1;
      bus.i_req_mean[b*32 +: 32] = m;
      bus.i_req_var[b*16 +: 16]  = v;
   endtask

   task automatic ret(input int b, input logic [31:0] m, input logic [15:0] q);
      bus.i_res_valid   = 1'b1;
      bus.i_res_bank_id = 2'(b);
      bus.i_res_mean    = m;
      bus.i_res_isq     = q;
      tick();
      bus.i_res_valid = 1'b0;
   endtask

   task automatic ack(input logic [3:0] m);
      bus.i_res_ready = m;
      tick();
      bus.i_res_ready = '0;
   endtask

   task automatic req_all(input logic [31:0] base);
      for (int b = 0; b < 4; b++) set_req(b, base + 32'(b), 16'h0100);
      tick();
      bus.i_req_valid = '0;
   endtask

   task automatic expect_issue(input string tag, input int b, input logic [31:0] m);
      tick();
      check({tag, "_valid"}, 64'(bus.o_calc_valid), 64'd1);
      check({tag, "_id"}, 64'(bus.o_calc_bank_id), 64'(b));
      check({tag, "_mean"}, 64'(bus.o_calc_mean), 64'(m));
   endtask

   task automatic drain_all(input logic [31:0] base);
      for (int b = 0; b < 4; b++) ret(b, base + 32'(b), 16'h1000 + 16'(b));
      check("drain_res_valid", 64'(bus.o_res_valid), 64'hF);
      ack(4'hF);
      check("drain_idle", 64'(bus.o_idle), 64'd1);
   endtask

   initial begin
      bus.i_en = 1'b0; bus.i_req_valid = '0; bus.i_req_mean = '0; bus.i_req_var = '0;
      bus.i_res_valid = 1'b0; bus.i_res_bank_id = '0; bus.i_res_mean = '0; bus.i_res_isq = '0;
      bus.i_res_ready = '0; bus.i_flush = 1'b0;
      #12;
      check("rst_calc_valid", 64'(bus.o_calc_valid), 64'd0);
      check("rst_res_valid", 64'(bus.o_res_valid), 64'd0);
      check("rst_err", 64'(bus.o_err), 64'd0);
      check("rst_idle", 64'(bus.o_idle), 64'd1);
      check("rst_flush_done", 64'(bus.o_flush_done), 64'd0);
      check("rst_calc_en_lo", 64'(bus.o_calc_en), 64'd0);
      bus.i_en = 1'b1;
      #1;
      check("rst_calc_en_hi", 64'(bus.o_calc_en), 64'd1);
      i_rst_n = 1'b1;
      tick();
      check("rst_ready", 64'(bus.o_req_ready), 64'hF);
      // single request on bank 2
      set_req(2, 32'h100, 16'h0400);
      tick();
      bus.i_req_valid = '0;
      check("single_ready", 64'(bus.o_req_ready), 64'hB);
      check("single_no_issue", 64'(bus.o_calc_valid), 64'd0);
      tick();
      check("single_valid", 64'(bus.o_calc_valid), 64'd1);
      check("single_id", 64'(bus.o_calc_bank_id), 64'd2);
      check("single_mean", 64'(bus.o_calc_mean), 64'h100);
      check("single_var", 64'(bus.o_calc_var), 64'h0400);
      tick();
      check("single_drop", 64'(bus.o_calc_valid), 64'd0);
      repeat (10) tick();
      ret(2, 32'h100, 16'h0400);
      check("single_res_valid", 64'(bus.o_res_valid), 64'h4);
      check("single_res_mean", 64'(bus.o_res_mean[64 +: 32]), 64'h100);
      check("single_res_isq", 64'(bus.o_res_isq[32 +: 16]), 64'h0400);
      check("single_idle_busy", 64'(bus.o_idle), 64'd0);
      ack(4'h4);
      check("single_ack_valid", 64'(bus.o_res_valid), 64'd0);
      check("single_ack_ready", 64'(bus.o_req_ready), 64'hF);
      check("single_err", 64'(bus.o_err), 64'd0);
      // reset brings rr_ptr back to 0, then all four request at once
      i_rst_n = 1'b0;
      #2;
      i_rst_n = 1'b1;
      tick();
      req_all(32'h10);
      for (int k = 0; k < 4; k++) expect_issue("rr0", k, 32'h10 + 32'(k));
      tick();
      check("rr0_drop", 64'(bus.o_calc_valid), 64'd0);
      drain_all(32'h10);
      // bank 1 granted last, so the next full round starts at bank 2
      set_req(1, 32'h41, 16'h0100);
      tick();
      bus.i_req_valid = '0;
      expect_issue("rr_b1", 1, 32'h41);
      ret(1, 32'h41, 16'h0800);
      ack(4'h2);
      req_all(32'h50);
      expect_issue("rr1_a", 2, 32'h52);
      expect_issue("rr1_b", 3, 32'h53);
      expect_issue("rr1_c", 0, 32'h50);
      expect_issue("rr1_d", 1, 32'h51);
      drain_all(32'h50);
      // stall for 5 cycles after the first issue
      req_all(32'h20);
      expect_issue("en_first", 2, 32'h22);
      bus.i_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("en_hold_valid", 64'(bus.o_calc_valid), 64'd1);
         check("en_hold_id", 64'(bus.o_calc_bank_id), 64'd2);
         check("en_hold_mean", 64'(bus.o_calc_mean), 64'h22);
         check("en_calc_en", 64'(bus.o_calc_en), 64'd0);
      end
      bus.i_en = 1'b1;
      expect_issue("en_res_a", 3, 32'h23);
      expect_issue("en_res_b", 0, 32'h20);
      expect_issue("en_res_c", 1, 32'h21);
      drain_all(32'h20);
      // back-pressure on bank 0
      set_req(0, 32'h5A5A5A5A, 16'h0100);
      tick();
      bus.i_req_valid = '0;
      expect_issue("bp_issue", 0, 32'h5A5A5A5A);
      ret(0, 32'h5A5A5A5A, 16'h0800);
      for (int k = 0; k < 20; k++) begin
         check("bp_ready0", 64'(bus.o_req_ready[0]), 64'd0);
         check("bp_valid0", 64'(bus.o_res_valid[0]), 64'd1);
         check("bp_mean0", 64'(bus.o_res_mean[0 +: 32]), 64'h5A5A5A5A);
         check("bp_isq0", 64'(bus.o_res_isq[0 +: 16]), 64'h0800);
         tick();
      end
      ack(4'h1);
      check("bp_ack_ready0", 64'(bus.o_req_ready[0]), 64'd1);
      check("bp_ack_valid0", 64'(bus.o_res_valid[0]), 64'd0);
      // flush with banks 1 and 3 pending (stage stalled so they stay PEND)
      bus.i_en = 1'b0;
      set_req(1, 32'h31, 16'h0100);
      set_req(3, 32'h33, 16'h0100);
      tick();
      bus.i_req_valid = '0;
      check("fl_ready_run", 64'(bus.o_req_ready), 64'h5);
      bus.i_flush = 1'b1;
      tick();
      bus.i_flush = 1'b0;
      check("fl_ready_drain", 64'(bus.o_req_ready), 64'd0);
      check("fl_done_early", 64'(bus.o_flush_done), 64'd0);
      bus.i_en = 1'b1;
      expect_issue("fl_issue_a", 1, 32'h31);
      expect_issue("fl_issue_b", 3, 32'h33);
      check("fl_ready_drain2", 64'(bus.o_req_ready), 64'd0);
      ret(1, 32'h31, 16'h0111);
      check("fl_done_b1", 64'(bus.o_flush_done), 64'd0);
      ret(3, 32'h33, 16'h0333);
      check("fl_done_b3", 64'(bus.o_flush_done), 64'd0);
      check("fl_ready_b3", 64'(bus.o_req_ready), 64'd0);
      tick();
      check("fl_done_pulse", 64'(bus.o_flush_done), 64'd1);
      check("fl_ready_done", 64'(bus.o_req_ready), 64'd0);
      check("fl_held", 64'(bus.o_res_valid), 64'hA);
      tick();
      check("fl_done_clear", 64'(bus.o_flush_done), 64'd0);
      check("fl_ready_back", 64'(bus.o_req_ready), 64'h5);
      check("fl_idle_held", 64'(bus.o_idle), 64'd0);
      check("fl_isq3", 64'(bus.o_res_isq[48 +: 16]), 64'h0333);
      ack(4'hA);
      check("fl_idle", 64'(bus.o_idle), 64'd1);
      check("fl_err", 64'(bus.o_err), 64'd0);
      // result for a FREE bank
      ret(0, 32'hDEAD, 16'hBEEF);
      check("err_set", 64'(bus.o_err), 64'd1);
      check("err_ignored", 64'(bus.o_res_valid), 64'd0);
      repeat (3) tick();
      check("err_sticky", 64'(bus.o_err), 64'd1);
      // asynchronous reset mid-flight
      set_req(2, 32'h77, 16'h0100);
      tick();
      bus.i_req_valid = '0;
      expect_issue("ar_issue", 2, 32'h77);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("ar_calc_valid", 64'(bus.o_calc_valid), 64'd0);
      check("ar_calc_id", 64'(bus.o_calc_bank_id), 64'd0);
      check("ar_calc_mean", 64'(bus.o_calc_mean), 64'd0);
      check("ar_err", 64'(bus.o_err), 64'd0);
      check("ar_idle", 64'(bus.o_idle), 64'd1);
      check("ar_res_valid", 64'(bus.o_res_valid), 64'd0);
      check("ar_calc_en", 64'(bus.o_calc_en), 64'd1);
      #1;
      i_rst_n = 1'b1;
      tick();
      check("ar_ready", 64'(bus.o_req_ready), 64'hF);
      ret(2, 32'h77, 16'h0100);
      check("ar_stale_res_err", 64'(bus.o_err), 64'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/ln_isqrt_sched.md
LN_ISQRT_SCHED -- requirements
Module: ln_isqrt_sched

Interface
REQ-001 Parameter NUM_BANKS, default 4: number of requesters (banks); bank id width is 2 bits.
REQ-002 Parameter PWL_LATENCY, default 12: latency in enabled cycles of the shared inverse-sqrt stage.
REQ-003 Parameter MEAN_W, default 32; parameter VAR_W, default 16; parameter ISQ_W, default 16.
REQ-004 i_clk  in  1  sole clock, rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_en  in  1  global pipeline enable; SHALL also drive o_calc_en directly.
REQ-007 i_req_valid  in  NUM_BANKS  per-bank request strobe.
REQ-008 i_req_mean  in  NUM_BANKS*MEAN_W  packed signed means; bank b occupies bits [b*MEAN_W +: MEAN_W].
REQ-009 i_req_var  in  NUM_BANKS*VAR_W  packed variances, packed the same way.
REQ-010 o_req_ready  out  NUM_BANKS  per-bank request acceptance.
REQ-011 o_calc_en, o_calc_valid  out  1 each  enable and valid to the shared stage.
REQ-012 o_calc_bank_id  out  2  bank id of the issued request.
REQ-013 o_calc_mean  out  MEAN_W  mean of the issued request.
REQ-014 o_calc_var  out  VAR_W  variance of the issued request.
REQ-015 i_res_valid  in  1  result strobe from the shared stage.
REQ-016 i_res_bank_id  in  2  bank id of the result.
REQ-017 i_res_mean  in  MEAN_W  mean of the result.
REQ-018 i_res_isq  in  ISQ_W  inverse-sqrt value of the result.
REQ-019 o_res_valid  out  NUM_BANKS  per-bank result valid.
REQ-020 i_res_ready  in  NUM_BANKS  per-bank result acknowledge.
REQ-021 o_res_mean, o_res_isq  out  NUM_BANKS*MEAN_W, NUM_BANKS*ISQ_W  packed per-bank result registers.
REQ-022 i_flush  in  1  drain request.
REQ-023 o_flush_done  out  1  drain-complete pulse.
REQ-024 o_idle  out  1  no request is pending, in flight or held.
REQ-025 o_err  out  1  sticky protocol error.

Function
REQ-026 Each bank SHALL have a state of FREE, PEND, FLY or HELD.
REQ-027 o_req_ready[b] SHALL be 1 iff bank b is FREE and the FSM is in RUN; it SHALL be a registered-state decode with no path from i_req_valid.
REQ-028 On i_req_valid[b] & o_req_ready[b], the slot SHALL latch mean and variance and bank b SHALL go FREE->PEND.
REQ-029 When i_en=1, the round-robin arbiter SHALL grant at most one PEND bank per cycle, searching from rr_ptr upward with wrap; the granted bank SHALL go PEND->FLY and rr_ptr SHALL become grant+1 mod NUM_BANKS.
REQ-030 The grant SHALL register o_calc_valid=1 with bank id, mean and variance on the next edge; with no grant, o_calc_valid=0.
REQ-031 When i_en=0, there SHALL be no grant, and o_calc_* and rr_ptr SHALL hold.
REQ-032 On i_res_valid with bank id b in FLY, the result SHALL be stored, b SHALL go FLY->HELD, and o_res_valid[b] SHALL be 1 from the next cycle.
REQ-033 i_res_valid for a bank not in FLY, or i_res_valid while the in-flight count is 0, SHALL set o_err and be otherwise ignored.
REQ-034 HELD with i_res_ready[b]=1 SHALL go to FREE and clear o_res_valid[b]; o_res_* data SHALL be stable while o_res_valid[b]=1.
REQ-035 The in-flight counter (width clog2(NUM_BANKS+1)) SHALL count +1 per issue and -1 per legal result; a simultaneous issue and result SHALL leave it unchanged.
REQ-036 Each bank is limited to one outstanding request, so result storage never overflows.
REQ-037 FSM RUN: when i_flush=1, SHALL go to DRAIN.
REQ-038 FSM DRAIN: all o_req_ready SHALL be 0; PEND banks SHALL still issue; when no bank is PEND or FLY, SHALL go to DONE.
REQ-039 FSM DONE: o_flush_done SHALL be 1 for exactly one cycle, then the FSM SHALL go to RUN; HELD results SHALL be retained through the whole flush.
REQ-040 o_idle SHALL equal (all banks FREE) & (FSM==RUN).

Reset
REQ-041 Asserting i_rst_n=0 SHALL immediately set all banks FREE, FSM=RUN, rr_ptr=0 and in-flight count=0.
REQ-042 During and after reset, all outputs SHALL be 0 except o_req_ready=all-ones (after release) and o_idle=1; o_calc_en SHALL follow i_en.
REQ-043 A reset mid-operation SHALL discard all in-flight work; the shared stage is reset by the same reset.

Structure
REQ-044 A shared package ln_pkg SHALL hold the bank-state enum, the FSM enum and the default values of NUM_BANKS and PWL_LATENCY.
REQ-045 The round-robin arbiter SHALL be a sub-module ln_rr_arb (request vector, pointer, enable -> one-hot grant and index).

Verification
REQ-046 Single request: bank2, mean=0x100, var=0x0400, i_en=1 -> o_calc_valid with id 2 one cycle after acceptance; a result injected 12 cycles later -> o_res_valid[2]=1 with the stored data.
REQ-047 All four banks request in the same cycle with rr_ptr=0 -> issue order 0,1,2,3 on consecutive cycles; a re-request of all four after bank 1 was last granted -> order 2,3,0,1.
REQ-048 i_en low for 5 cycles mid-stream -> no issue and o_calc_* frozen; issue resumes in order when i_en returns high.
REQ-049 Back-pressure: i_res_ready[0]=0 for 20 cycles -> o_req_ready[0]=0 throughout and the data stays stable; ready returns one cycle after acknowledge.
REQ-050 Flush with two banks PEND -> both issue and return, then a single o_flush_done pulse; o_req_ready=0 during DRAIN.
REQ-051 A result for a FREE bank -> o_err=1 and stays set; asserting i_rst_n=0 mid-flight -> all outputs return to reset values asynchronously.
